// File: rtl/sks1s2_unpack.sv
// MLDSA s1/s2 secret-key unpacker: 3-bit packed fields from keymem -> Z_q coefficients,
// eight per cycle split across two coefficient-memory write ports.
package sks1s2_unpack_pkg;
   localparam int unsigned MEM_AW = 15;

   typedef logic [MEM_AW-1:0] mem_addr_t;

   typedef enum logic [1:0] {
      RW_IDLE  = 2'b00,
      RW_READ  = 2'b01,
      RW_WRITE = 2'b10
   } mem_rw_e;

   typedef struct packed {
      mem_rw_e   rd_wr_en;
      mem_addr_t addr;
   } mem_if_t;
endpackage

module sks1s2_unpack
   import sks1s2_unpack_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = 15,
   parameter int unsigned MLDSA_Q        = 8380417,
   parameter int unsigned MLDSA_L        = 7,
   parameter int unsigned MLDSA_K        = 8,
   parameter int unsigned MLDSA_N        = 256,
   parameter int unsigned REG_SIZE       = 24,
   parameter int unsigned AHB_DATA_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           zeroize,
   input  logic                           unpack_enable,
   input  logic [MEM_ADDR_WIDTH-1:0]      src_base_addr,
   input  logic [MEM_ADDR_WIDTH-1:0]      dest_base_addr,
   output mem_if_t                        keymem_rd_req,
   input  logic [AHB_DATA_WIDTH-1:0]      keymem_rd_data,
   output mem_if_t                        mem_a_wr_req,
   output mem_if_t                        mem_b_wr_req,
   output logic [3:0][REG_SIZE-1:0]       mem_a_wr_data,
   output logic [3:0][REG_SIZE-1:0]       mem_b_wr_data,
   output logic                           unpack_done,
   output logic                           unpack_error
);

   localparam int unsigned NUM_GROUPS = (MLDSA_K + MLDSA_L) * MLDSA_N * 3 / 96;
   localparam int unsigned NUM_SLICES = 4 * NUM_GROUPS;
   localparam int unsigned CNT_W      = $clog2(NUM_SLICES + 1);

   localparam logic [REG_SIZE-1:0] Q_M1 = REG_SIZE'(MLDSA_Q - 1);
   localparam logic [REG_SIZE-1:0] Q_M2 = REG_SIZE'(MLDSA_Q - 2);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_WRITE   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   logic [2:0]                  state;
   logic [1:0]                  fetch_idx;
   logic [CNT_W-1:0]            word_cnt;
   logic [CNT_W-1:0]            slice_cnt;
   logic                        rd_valid;
   logic [1:0]                  rd_idx;
   logic [95:0]                 buffer;
   logic [MEM_ADDR_WIDTH-1:0]   src_q;
   logic [MEM_ADDR_WIDTH-1:0]   dest_q;

   logic [23:0]                 slice;
   logic [7:0][2:0]             fields;
   logic [7:0][REG_SIZE-1:0]    coeffs;
   logic                        slice_bad;
   logic [MEM_ADDR_WIDTH-1:0]   wr_addr_a;
   logic [MEM_ADDR_WIDTH-1:0]   wr_addr_b;

   always_comb begin
      case (slice_cnt[1:0])
         2'd0:    slice = buffer[23:0];
         2'd1:    slice = buffer[47:24];
         2'd2:    slice = buffer[71:48];
         default: slice = buffer[95:72];
      endcase
   end

   // Field 2 encodes zero; 0/1 are positive and 3/4 wrap to q-1/q-2.
   always_comb begin
      fields    = slice;
      coeffs    = '0;
      slice_bad = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         case (fields[i])
            3'd0:    coeffs[i] = REG_SIZE'(2);
            3'd1:    coeffs[i] = REG_SIZE'(1);
            3'd2:    coeffs[i] = '0;
            3'd3:    coeffs[i] = Q_M1;
            3'd4:    coeffs[i] = Q_M2;
            default: slice_bad = 1'b1;
         endcase
      end
   end

   always_comb begin
      wr_addr_a = dest_q + MEM_ADDR_WIDTH'({slice_cnt, 1'b0});
      wr_addr_b = wr_addr_a + MEM_ADDR_WIDTH'(1);
   end

   // Read request is combinational so data lands one cycle later, during the next state.
   always_comb begin
      keymem_rd_req.rd_wr_en = RW_IDLE;
      keymem_rd_req.addr     = '0;
      if (state == ST_FETCH) begin
         keymem_rd_req.rd_wr_en = RW_READ;
         keymem_rd_req.addr     = mem_addr_t'(src_q + MEM_ADDR_WIDTH'(word_cnt));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         fetch_idx     <= '0;
         word_cnt      <= '0;
         slice_cnt     <= '0;
         rd_valid      <= 1'b0;
         rd_idx        <= '0;
         buffer        <= '0;
         src_q         <= '0;
         dest_q        <= '0;
         mem_a_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_b_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_a_wr_data <= '0;
         mem_b_wr_data <= '0;
         unpack_done   <= 1'b0;
         unpack_error  <= 1'b0;
      end else if (zeroize) begin
         state         <= ST_IDLE;
         fetch_idx     <= '0;
         word_cnt      <= '0;
         slice_cnt     <= '0;
         rd_valid      <= 1'b0;
         rd_idx        <= '0;
         buffer        <= '0;
         src_q         <= '0;
         dest_q        <= '0;
         mem_a_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_b_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_a_wr_data <= '0;
         mem_b_wr_data <= '0;
         unpack_done   <= 1'b0;
         unpack_error  <= 1'b0;
      end else begin
         unpack_done   <= 1'b0;
         unpack_error  <= 1'b0;
         mem_a_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_b_wr_req  <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_a_wr_data <= '0;
         mem_b_wr_data <= '0;
         rd_valid      <= (state == ST_FETCH);
         rd_idx        <= fetch_idx;

         if (rd_valid) begin
            case (rd_idx)
               2'd0:    buffer[31:0]  <= keymem_rd_data[31:0];
               2'd1:    buffer[63:32] <= keymem_rd_data[31:0];
               default: buffer[95:64] <= keymem_rd_data[31:0];
            endcase
         end

         case (state)
            ST_IDLE: begin
               if (unpack_enable) begin
                  state     <= ST_FETCH;
                  src_q     <= src_base_addr;
                  dest_q    <= dest_base_addr;
                  fetch_idx <= '0;
               end
            end
            ST_FETCH: begin
               word_cnt <= word_cnt + CNT_W'(1);
               if (fetch_idx == 2'd2) begin
                  fetch_idx <= '0;
                  state     <= ST_CAPTURE;
               end else begin
                  fetch_idx <= fetch_idx + 2'd1;
               end
            end
            ST_CAPTURE: state <= ST_WRITE;
            ST_WRITE: begin
               if (slice_bad) begin
                  unpack_error <= 1'b1;
                  state        <= ST_IDLE;
                  word_cnt     <= '0;
                  slice_cnt    <= '0;
                  fetch_idx    <= '0;
               end else begin
                  mem_a_wr_req  <= '{rd_wr_en: RW_WRITE, addr: mem_addr_t'(wr_addr_a)};
                  mem_b_wr_req  <= '{rd_wr_en: RW_WRITE, addr: mem_addr_t'(wr_addr_b)};
                  mem_a_wr_data <= coeffs[3:0];
                  mem_b_wr_data <= coeffs[7:4];
                  slice_cnt     <= slice_cnt + CNT_W'(1);
                  if (slice_cnt[1:0] == 2'd3) begin
                     state <= (slice_cnt == CNT_W'(NUM_SLICES - 1)) ? ST_DONE : ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               unpack_done <= 1'b1;
               state       <= ST_IDLE;
               word_cnt    <= '0;
               slice_cnt   <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sks1s2_unpack.sv
// Scoreboard bench for sks1s2_unpack: a bitstream-level model predicts reads, writes,
// done and error; a negedge monitor pops and compares whatever the DUT presents.
module tb_sks1s2_unpack;
   import sks1s2_unpack_pkg::*;

   localparam int unsigned AW   = 15;
   localparam int unsigned MASK = (1 << AW) - 1;
   localparam int unsigned NG   = 120;
   localparam int unsigned Q    = 8380417;
   localparam int EV_WR   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int           kind;
      int unsigned  a;
      int unsigned  b;
      logic [191:0] lanes;
   } ev_t;

   logic                 clk;
   logic                 reset;
   logic                 zeroize;
   logic                 unpack_enable;
   logic [AW-1:0]        src_base_addr;
   logic [AW-1:0]        dest_base_addr;
   mem_if_t              keymem_rd_req;
   logic [31:0]          keymem_rd_data;
   mem_if_t              mem_a_wr_req;
   mem_if_t              mem_b_wr_req;
   logic [3:0][23:0]     mem_a_wr_data;
   logic [3:0][23:0]     mem_b_wr_data;
   logic                 unpack_done;
   logic                 unpack_error;

   logic [31:0]          keymem [0:32767];
   ev_t                  ev_q[$];
   int unsigned          rd_q[$];
   int                   n_chk;
   int                   n_fail;
   bit                   mon_en;
   int                   stray;
   int                   cyc;
   int                   last_wr_cyc;

   sks1s2_unpack #(
      .MEM_ADDR_WIDTH(15), .MLDSA_Q(8380417), .MLDSA_L(7), .MLDSA_K(8),
      .MLDSA_N(256), .REG_SIZE(24), .AHB_DATA_WIDTH(32)
   ) dut (
      .clk(clk), .reset(reset), .zeroize(zeroize), .unpack_enable(unpack_enable),
      .src_base_addr(src_base_addr), .dest_base_addr(dest_base_addr),
      .keymem_rd_req(keymem_rd_req), .keymem_rd_data(keymem_rd_data),
      .mem_a_wr_req(mem_a_wr_req), .mem_b_wr_req(mem_b_wr_req),
      .mem_a_wr_data(mem_a_wr_data), .mem_b_wr_data(mem_b_wr_data),
      .unpack_done(unpack_done), .unpack_error(unpack_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keymem: one-cycle read latency, garbage when not reading.
   always @(posedge clk) begin
      if (keymem_rd_req.rd_wr_en == RW_READ) keymem_rd_data <= keymem[keymem_rd_req.addr];
      else keymem_rd_data <= $urandom();
   end

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic int unsigned get_field(input int unsigned src, input int unsigned c);
      int unsigned v = 0;
      for (int unsigned b = 0; b < 3; b++) begin
         int unsigned bp = 3 * c + b;
         if (keymem[(src + bp / 32) & MASK][bp % 32]) v |= (1 << b);
      end
      return v;
   endfunction

   task automatic set_field(input int unsigned src, input int unsigned c, input int unsigned val);
      for (int unsigned b = 0; b < 3; b++) begin
         int unsigned bp = 3 * c + b;
         keymem[(src + bp / 32) & MASK][bp % 32] = val[b];
      end
   endtask

   function automatic int unsigned fmap(input int unsigned f);
      case (f)
         0: return 2;
         1: return 1;
         2: return 0;
         3: return Q - 1;
         4: return Q - 2;
         default: return 0;
      endcase
   endfunction

   task automatic clear_region(input int unsigned src);
      for (int unsigned w = 0; w < 3 * NG; w++) keymem[(src + w) & MASK] = '0;
   endtask

   task automatic fill_rand(input int unsigned src);
      for (int unsigned c = 0; c < 32 * NG; c++) set_field(src, c, $urandom_range(0, 4));
   endtask

   // Coefficient c sits at stream bits [3c+2:3c]; slice s holds coefficients 8s..8s+7.
   task automatic build_expect(input int unsigned src, input int unsigned dest);
      ev_t e;
      for (int unsigned g = 0; g < NG; g++) begin
         for (int unsigned w = 0; w < 3; w++) rd_q.push_back((src + 3 * g + w) & MASK);
         for (int unsigned j = 0; j < 4; j++) begin
            int unsigned s = 4 * g + j;
            bit bad = 0;
            e.lanes = '0;
            for (int unsigned i = 0; i < 8; i++) begin
               int unsigned f = get_field(src, 8 * s + i);
               if (f > 4) bad = 1;
               e.lanes[24 * i +: 24] = 24'(fmap(f));
            end
            if (bad) begin
               e.kind = EV_ERR;
               ev_q.push_back(e);
               return;
            end
            e.kind = EV_WR;
            e.a    = (dest + 2 * s) & MASK;
            e.b    = (dest + 2 * s + 1) & MASK;
            ev_q.push_back(e);
         end
      end
      e.kind = EV_DONE;
      ev_q.push_back(e);
   endtask

   task automatic take(input int kind);
      ev_t e;
      if (ev_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d, required none", kind);
      end else begin
         e = ev_q.pop_front();
         chk("event_kind", kind, e.kind);
         if (kind == EV_WR && e.kind == EV_WR) begin
            chk("a_cmd", mem_a_wr_req.rd_wr_en, RW_WRITE);
            chk("b_cmd", mem_b_wr_req.rd_wr_en, RW_WRITE);
            chk("a_addr", mem_a_wr_req.addr, e.a);
            chk("b_addr", mem_b_wr_req.addr, e.b);
            chk("lanes", {mem_b_wr_data, mem_a_wr_data}, e.lanes);
            last_wr_cyc = cyc;
         end
         if (kind == EV_DONE) chk("done_latency", cyc - last_wr_cyc, 1);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         cyc++;
         if (!mon_en) begin
            if (unpack_done || unpack_error) stray++;
         end else begin
            if (keymem_rd_req.rd_wr_en == RW_READ) begin
               if (rd_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL stray_read: got read at %0h, required none", keymem_rd_req.addr);
               end else begin
                  chk("rd_addr", keymem_rd_req.addr, rd_q.pop_front());
               end
            end
            if (mem_a_wr_req.rd_wr_en == RW_WRITE || mem_b_wr_req.rd_wr_en == RW_WRITE) take(EV_WR);
            if (unpack_done) take(EV_DONE);
            if (unpack_error) take(EV_ERR);
         end
      end
   end

   task automatic start(input int unsigned src, input int unsigned dest);
      src_base_addr  = AW'(src);
      dest_base_addr = AW'(dest);
      unpack_enable  = 1'b1;
      @(negedge clk);
      unpack_enable  = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 1200 && (ev_q.size() != 0 || rd_q.size() != 0); i++) @(negedge clk);
      chk({nm, "_drain"}, ev_q.size() + rd_q.size(), 0);
      ev_q.delete();
      rd_q.delete();
      repeat (4) @(negedge clk);
   endtask

   task automatic run(input string nm, input int unsigned src, input int unsigned dest);
      build_expect(src, dest);
      start(src, dest);
      drain(nm);
   endtask

   initial begin
      int unsigned src;
      n_chk = 0; n_fail = 0; mon_en = 1; stray = 0; cyc = 0; last_wr_cyc = 0;
      reset = 1'b1; zeroize = 1'b0; unpack_enable = 1'b0;
      src_base_addr = '0; dest_base_addr = '0;
      for (int i = 0; i < 32768; i++) keymem[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset_reqs", {keymem_rd_req, mem_a_wr_req, mem_b_wr_req, unpack_done, unpack_error}, '0);
      chk("reset_data", {mem_b_wr_data, mem_a_wr_data}, '0);
      reset = 1'b0;
      @(negedge clk);

      run("all_zero", 32'h0100, 32'h0200);

      src = 32'h1000;
      clear_region(src);
      keymem[src] = 32'h49249249; keymem[src + 1] = 32'h92492492; keymem[src + 2] = 32'h24924924;
      run("all_ones", src, 32'h3000);

      src = 32'h2000;
      clear_region(src);
      set_field(src, 0, 3); set_field(src, 1, 4); set_field(src, 2, 2);
      run("q_minus", src, 32'h4000);

      src = 32'h2400;
      clear_region(src);
      keymem[src] = 32'h00000007;
      run("invalid_w0", src, 32'h5000);

      src = $urandom_range(0, 32'h7000);
      fill_rand(src);
      run("random", src, $urandom_range(0, MASK));

      // Abort in group 50 with checking off, then restart across the address wrap.
      src = 32'h0800;
      fill_rand(src);
      mon_en = 0; stray = 0;
      start(src, 32'h6000);
      repeat (50 * 8 + 3) @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      chk("zeroize_reqs", {keymem_rd_req, mem_a_wr_req, mem_b_wr_req, unpack_done, unpack_error}, '0);
      chk("zeroize_data", {mem_b_wr_data, mem_a_wr_data}, '0);
      repeat (5) @(negedge clk);
      chk("zeroize_no_done", stray, 0);
      mon_en = 1;
      src = 32'h7FFF;
      fill_rand(src);
      run("wrap", src, 32'h7FF0);

      src = 32'h3000;
      fill_rand(src);
      build_expect(src, 32'h1234);
      start(src, 32'h1234);
      repeat (100) @(negedge clk);
      start(32'h0111, 32'h0222);
      repeat (300) @(negedge clk);
      start(32'h0333, 32'h0444);
      drain("reenable");

      src = 32'h5000;
      fill_rand(src);
      set_field(src, $urandom_range(200, 3000), $urandom_range(5, 7));
      run("invalid_mid", src, $urandom_range(0, MASK));

      run("after_error", src + 32'h200, 32'h0010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
